// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches one word at a time over
// imem req/ack and holds it for decode, honouring taken-branch redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic        pend;
  logic [31:0] pend_target;
  logic [31:0] target;

  // Handshakes: imem transfers when imem_req && imem_ack; decode transfers when
  // inst_valid && inst_ready. Request/valid never depend on ack/ready/redirect.
  assign target     = redirect_target & 32'hFFFF_FFFC;
  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst        <= NOP;
      inst_pc     <= RESET_PC;
      pend        <= 1'b0;
      pend_target <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= target;
          state <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            // A stale fetch is dropped; the same-cycle redirect beats the pending one.
            pend <= 1'b0;
            if (redirect) begin
              pc <= target;
            end else if (pend) begin
              pc <= pend_target;
            end else begin
              inst    <= imem_rdata;
              inst_pc <= pc;
              state   <= HOLD;
            end
          end else if (redirect) begin
            pend        <= 1'b1;
            pend_target <= target;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= target;
            state <= REQ;
          end else if (inst_ready) begin
            pc    <= pc + 32'd4;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
